// File: rtl/alu_pkg.sv
// Shared opcode constants and control-FSM state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_SLL   = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_OR    = 6'b000101;
  localparam logic [5:0] OP_XOR   = 6'b000110;
  localparam logic [5:0] OP_SGT   = 6'b000111;
  localparam logic [5:0] OP_SLTU  = 6'b001000;
  localparam logic [5:0] OP_SRL   = 6'b001001;
  localparam logic [5:0] OP_SRA   = 6'b001010;
  localparam logic [5:0] OP_AND   = 6'b001011;
  localparam logic [5:0] OP_MUL   = 6'b010000;
  localparam logic [5:0] OP_MULHU = 6'b010001;
  localparam logic [5:0] OP_DIVU  = 6'b010010;
  localparam logic [5:0] OP_REMU  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide; one bit per cycle.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            div_i,
  input  logic            hi_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q;
  logic            div_q;
  logic            hi_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] lo_d;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            ge;

  // acc holds the product high half / partial remainder, lo the product low half / quotient.
  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    shifted = {acc_q, lo_q[XLEN-1]};
    ge      = (shifted >= {1'b0, opnd_q});
    acc_d   = '0;
    lo_d    = '0;
    if (div_q) begin
      acc_d = ge ? XLEN'(shifted - {1'b0, opnd_q}) : shifted[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], ge};
    end else begin
      acc_d = sum[XLEN:1];
      lo_d  = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // done_o marks the edge that performs the final iteration; res_o is that step's outcome.
  assign done_o = busy_q && (cnt_q == CW'(XLEN-1));
  assign res_o  = hi_q ? acc_d : lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      acc_q  <= '0;
      lo_q   <= a_i;
      opnd_q <= b_i;
      div_q  <= div_i;
      hi_q   <= hi_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete in one cycle, MUL/DIV iterate XLEN cycles.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [OPW-1:0]  alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  state_e                 state_q;
  logic [XLEN-1:0]        result_q;
  logic [XLEN-1:0]        alu_res;
  logic signed [XLEN-1:0] s1_s;
  logic signed [XLEN-1:0] s2_s;
  logic [SHW-1:0]         shamt;
  logic                   multi;
  logic                   div_op;
  logic                   hi_op;
  logic                   start;
  logic                   it_done;
  logic [XLEN-1:0]        it_res;

  assign s1_s  = src1;
  assign s2_s  = src2;
  assign shamt = src2[SHW-1:0];

  // Divide by zero never enters the iterator; its fixed result is produced here.
  always_comb begin
    alu_res = '0;
    multi   = 1'b0;
    div_op  = 1'b0;
    hi_op   = 1'b0;
    case (alu_control)
      OPW'(OP_ADD):   alu_res = src1 + src2;
      OPW'(OP_SUB):   alu_res = src1 - src2;
      OPW'(OP_SLL):   alu_res = src1 << shamt;
      OPW'(OP_SLT):   alu_res = XLEN'(s1_s < s2_s);
      OPW'(OP_OR):    alu_res = src1 | src2;
      OPW'(OP_XOR):   alu_res = src1 ^ src2;
      OPW'(OP_SGT):   alu_res = XLEN'(s1_s > s2_s);
      OPW'(OP_SLTU):  alu_res = XLEN'(src1 < src2);
      OPW'(OP_SRL):   alu_res = src1 >> shamt;
      OPW'(OP_SRA):   alu_res = s1_s >>> shamt;
      OPW'(OP_AND):   alu_res = src1 & src2;
      OPW'(OP_MUL):   multi   = 1'b1;
      OPW'(OP_MULHU): begin
        multi = 1'b1;
        hi_op = 1'b1;
      end
      OPW'(OP_DIVU):  begin
        multi   = (src2 != '0);
        div_op  = 1'b1;
        alu_res = '1;
      end
      OPW'(OP_REMU):  begin
        multi   = (src2 != '0);
        div_op  = 1'b1;
        hi_op   = 1'b1;
        alu_res = src1;
      end
      default:        alu_res = '0;
    endcase
  end

  assign start = (state_q == IDLE) && in_valid && multi;

  alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .div_i   (div_op),
    .hi_i    (hi_op),
    .a_i     (src1),
    .b_i     (src2),
    .done_o  (it_done),
    .res_o   (it_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (multi) begin
            state_q <= BUSY;
          end else begin
            state_q  <= DONE;
            result_q <= alu_res;
          end
        end
        BUSY: if (it_done) begin
          state_q  <= DONE;
          result_q <= it_res;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (XLEN=32): results, latencies, hold, ignore and abort behaviour.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [5:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  alu_mc #(.XLEN(32), .OPW(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, then check latency and result.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; src1 = a; src2 = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_control = ~op; src1 = ~a; src2 = ~b;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; src1 = '0; src2 = '0; alu_control = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);

    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    run_op("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op("sll31", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 1);
    run_op("sll_mask", OP_SLL, 32'h1, 32'h24, 32'h10, 1);
    run_op("sra", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run_op("srl", OP_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 1);
    run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
    run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    run_op("sgt", OP_SGT, 32'h1, 32'hFFFF_FFFF, 32'h1, 1);
    run_op("sgt_neg", OP_SGT, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    run_op("or", OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
    run_op("xor", OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1);
    run_op("and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    run_op("illegal3f", 6'h3F, 32'h1234, 32'h5678, 32'h0, 1);
    run_op("illegal00", 6'h00, 32'h1234, 32'h5678, 32'h0, 1);

    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33);
    run_op("mul", OP_MUL, 32'd12345, 32'd678, 32'd8369910, 33);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 33);
    run_op("remu_16", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
    run_op("divu_z", OP_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("remu_z", OP_REMU, 32'd5, 32'h0, 32'd5, 1);

    // Consumer stalls: result and handshake must hold.
    out_ready = 1'b0;
    run_op("hold", OP_SUB, 32'd10, 32'd3, 32'd7, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_res", 64'(result), 64'd7);
      chk("hold_ovld", 64'(out_valid), 64'd1);
      chk("hold_irdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_ovld", 64'(out_valid), 64'd0);
    chk("hold_release_irdy", 64'(in_ready), 64'd1);

    // Requests during BUSY must be ignored.
    @(negedge clk);
    in_valid = 1'b1; alu_control = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      in_valid = i[0]; alu_control = OP_ADD; src1 = 32'd1; src2 = 32'd1;
      chk("busy_irdy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_ign_lat", 64'(lat), 64'd33);
    chk("busy_ign_res", 64'(result), 64'd14);
    @(posedge clk); #1;

    // Reset mid-BUSY aborts without emitting a result.
    @(negedge clk);
    in_valid = 1'b1; alu_control = OP_MUL; src1 = 32'd3; src2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_irdy", 64'(in_ready), 64'd1);
    chk("abort_ovld", 64'(out_valid), 64'd0);
    chk("abort_res", 64'(result), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_out", 64'(seen), 64'd0);
    run_op("add_after_abort", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
